// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a requester and apb_mem_slave.
// The master modport drives the request side; the slave modport
// returns pready/pslverr/prdata.
interface apb_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB completer backed by a word-addressed register memory of
// MEM_SIZE x DATA_WIDTH bits mapped at BASE_ADDR. Each transfer sees
// WAIT_CYCLE wait states, then one cycle with pready high.
//
// Optional feature macro: APB_MEM_SLAVE_ERR_EN
//   defined   : out-of-window or misaligned addresses raise pslverr;
//               such reads return 0 and such writes are dropped.
//   undefined : no error detection, addresses alias modulo MEM_SIZE words,
//               paddr[1:0] ignored, pslverr stays 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer in flight; pready low; waits for a setup phase
// WAIT   | access phase, counting down wait states; psel low aborts
// ACK    | pready high for one cycle; write commits on the exiting edge
module apb_mem_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_SIZE   = 256,
    parameter int                    WAIT_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    apb_mem_slave_if.slave  bus
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLE);
    // One bit wider so the end of the window cannot wrap to zero.
    localparam logic [ADDR_WIDTH:0] END_ADDR =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    logic                  w_setup;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;
    logic                  w_commit;

    assign w_setup = bus.psel && !bus.penable;
    assign w_off   = bus.paddr - BASE_ADDR;
    assign w_idx   = IDX_W'(w_off >> 2);

`ifdef APB_MEM_SLAVE_ERR_EN
    assign w_err = (bus.paddr < BASE_ADDR)
                || ({1'b0, bus.paddr} >= END_ADDR)
                || (bus.paddr[1:0] != 2'b00);
`else
    assign w_err = 1'b0;
`endif

    // The write lands only if the requester still holds the access phase.
    assign w_commit = (r_state == S_ACK) && r_write && bus.psel
                   && bus.penable && !r_err;

    // Transfer sequencing with registered pready/pslverr/prdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_write <= bus.pwrite;
                        r_idx   <= w_idx;
                        r_wdata <= bus.pwdata;
                        r_err   <= w_err;
                        if (WAIT_CYCLE == 0) begin
                            r_state   <= S_ACK;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= (bus.pwrite || w_err) ? '0 : r_mem[w_idx];
                        end else begin
                            r_cnt   <= WAIT_LD;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.psel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state   <= S_ACK;
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_prdata  <= (r_write || r_err) ? '0 : r_mem[r_idx];
                        end
                    end
                end
                S_ACK: begin
                    r_state   <= S_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end
            endcase
        end
    end

    // Storage array: cleared on reset, written on the edge that ends ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.pready  = r_pready;
    assign bus.pslverr = r_pslverr;
    assign bus.prdata  = r_prdata;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave. Four instances with 1, 0, 3 and 15
// wait states share one set of bus inputs; every transfer is scored against
// a plain array memory model, including latency and error behaviour.
module tb_apb_mem_slave;
    localparam int MEM    = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int WC [4] = '{1, 0, 3, 15};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mem_m [MEM];

    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_w1 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_w0 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_w3 ();
    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_w15 ();

    assign if_w1.psel = psel;   assign if_w1.penable = penable;   assign if_w1.pwrite = pwrite;
    assign if_w1.paddr = paddr; assign if_w1.pwdata = pwdata;
    assign if_w0.psel = psel;   assign if_w0.penable = penable;   assign if_w0.pwrite = pwrite;
    assign if_w0.paddr = paddr; assign if_w0.pwdata = pwdata;
    assign if_w3.psel = psel;   assign if_w3.penable = penable;   assign if_w3.pwrite = pwrite;
    assign if_w3.paddr = paddr; assign if_w3.pwdata = pwdata;
    assign if_w15.psel = psel;  assign if_w15.penable = penable;  assign if_w15.pwrite = pwrite;
    assign if_w15.paddr = paddr; assign if_w15.pwdata = pwdata;

    apb_mem_slave #(.BASE_ADDR(BASE), .MEM_SIZE(MEM), .WAIT_CYCLE(1))
        u_dut_w1 (.clk(clk), .rst_n(rst_n), .bus(if_w1));
    apb_mem_slave #(.BASE_ADDR(BASE), .MEM_SIZE(MEM), .WAIT_CYCLE(0))
        u_dut_w0 (.clk(clk), .rst_n(rst_n), .bus(if_w0));
    apb_mem_slave #(.BASE_ADDR(BASE), .MEM_SIZE(MEM), .WAIT_CYCLE(3))
        u_dut_w3 (.clk(clk), .rst_n(rst_n), .bus(if_w3));
    apb_mem_slave #(.BASE_ADDR(BASE), .MEM_SIZE(MEM), .WAIT_CYCLE(15))
        u_dut_w15 (.clk(clk), .rst_n(rst_n), .bus(if_w15));

    logic [3:0]  w_rdy;
    logic [3:0]  w_slverr;
    logic [31:0] w_rd [4];
    assign w_rdy    = {if_w15.pready, if_w3.pready, if_w0.pready, if_w1.pready};
    assign w_slverr = {if_w15.pslverr, if_w3.pslverr, if_w0.pslverr, if_w1.pslverr};
    assign w_rd[0]  = if_w1.prdata;
    assign w_rd[1]  = if_w0.prdata;
    assign w_rd[2]  = if_w3.prdata;
    assign w_rd[3]  = if_w15.prdata;

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a);
`ifdef APB_MEM_SLAVE_ERR_EN
        longint la = longint'(a);
        return (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * MEM) || (a % 4 != 0);
`else
        return (a != a);
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        return int'((off / 4) % MEM);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MEM; i++) mem_m[i] = '0;
    endtask

    // One full transfer seen by all four instances; scores latency,
    // single-cycle pready, pslverr and read data.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input string tag);
        bit          exp_err = m_err(a);
        int          idx     = m_idx(a);
        logic [31:0] exp_rd  = (wr || exp_err) ? 32'h0 : mem_m[idx];
        int          lat  [4];
        int          hits [4];
        logic [31:0] rd   [4];
        logic        er   [4];
        int          cyc;
        bit          done;
        for (int k = 0; k < 4; k++) begin
            lat[k] = -1; hits[k] = 0; rd[k] = '0; er[k] = 1'b0;
        end
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        // Post-setup changes must be ignored by the completer.
        penable = 1'b1; paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc <= 40) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (w_rdy[k]) begin
                    hits[k]++;
                    if (hits[k] == 1) begin
                        lat[k] = cyc; rd[k] = w_rd[k]; er[k] = w_slverr[k];
                    end
                end
            end
            done = (hits[0] > 0) && (hits[1] > 0) && (hits[2] > 0) && (hits[3] > 0);
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) if (w_rdy[k]) hits[k]++;
        check_eq($sformatf("%s_idle_prdata", tag), w_rd[0], 32'h0);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("%s_lat_w%0d", tag, WC[k]), lat[k], WC[k] + 1);
            check_eq($sformatf("%s_rdycycles_w%0d", tag, WC[k]), hits[k], 1);
            check_eq($sformatf("%s_slverr_w%0d", tag, WC[k]), {31'b0, er[k]}, {31'b0, exp_err});
            if (!wr) check_eq($sformatf("%s_rdata_w%0d", tag, WC[k]), rd[k], exp_rd);
        end
        if (wr && !exp_err) mem_m[idx] = d;
    endtask

    // Setup then psel dropped in the first access cycle: slow instances
    // must abort silently, and the lone zero-wait ACK sees psel low so no write.
    task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
        int hits [4];
        for (int k = 0; k < 4; k++) hits[k] = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (w_rdy[k]) hits[k]++;
        end
        check_eq("abort_rdy_w1", hits[0], 0);
        check_eq("abort_rdy_w3", hits[2], 0);
        check_eq("abort_rdy_w15", hits[3], 0);
    endtask

    // Reset pulled while the one-wait instance is in ACK of a write.
    task automatic reset_in_ack(input logic [31:0] a, input logic [31:0] d);
        int cyc = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!w_rdy[0] && cyc < 10);
        check_eq("rst_ack_seen", {31'b0, w_rdy[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_ack_pready_drop", {28'b0, w_rdy}, 32'h0);
        check_eq("rst_ack_prdata", w_rd[0], 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [31:0] a;
        int r;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        rst_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pready", {28'b0, w_rdy}, 32'h0);
        check_eq("rst_pslverr", {28'b0, w_slverr}, 32'h0);
        check_eq("rst_prdata", w_rd[0], 32'h0);
        rst_n = 1'b1;

        xfer(1'b0, 32'h0000_0010, 32'h0, "rst_read");
        xfer(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, "wr4");
        xfer(1'b0, 32'h0000_0004, 32'h0, "rd4");
        check_eq("rd4_model", mem_m[1], 32'hDEAD_BEEF);

        xfer(1'b1, BASE + 32'h400, 32'h1234_5678, "wr_oor");
        xfer(1'b0, BASE, 32'h0, "rd_word0");
        xfer(1'b0, 32'h0000_0002, 32'h0, "rd_misalign");

        xfer(1'b1, 32'h0000_0020, 32'h0BAD_F00D, "wr20");
        abort_write(32'h0000_0020, 32'hFFFF_0000);
        xfer(1'b0, 32'h0000_0020, 32'h0, "rd20_after_abort");

        for (int t = 0; t < 90; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, MEM - 1)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, MEM - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'h400 + (32'($urandom_range(0, 1023)) << 2);
            else             a = 32'h3FC;
            xfer(1'($urandom), a, $urandom, $sformatf("rnd%0d", t));
        end

        xfer(1'b1, 32'h0000_0030, 32'hCAFE_0001, "wr30");
        reset_in_ack(32'h0000_0030, 32'h5555_AAAA);
        xfer(1'b0, 32'h0000_0030, 32'h0, "rd30_after_rst");
        xfer(1'b1, 32'h0000_0008, 32'hA5A5_A5A5, "wr8");
        xfer(1'b0, 32'h0000_0008, 32'h0, "rd8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

APB completer that terminates the bus driven by `apb_master`. It holds a word-addressed memory of `MEM_SIZE` × `DATA_WIDTH` bits mapped at `BASE_ADDR`. It inserts a fixed number of wait states per transfer and flags illegal accesses on `pslverr`. It is the downstream stage of the APB bridge datapath and consumes every `psel`/`penable`/`paddr`/`pwrite`/`pwdata` transfer the master issues.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0.
- `ADDR_WIDTH`, 32, width of `paddr`.
- `DATA_WIDTH`, 32, width of `pwdata` and `prdata`.
- `MEM_SIZE`, 256, number of words; must be a power of two, range 2–1024.
- `WAIT_CYCLE`, 1, wait states per transfer (`pready` low in access phase); range 0–15.
- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `psel` in 1: slave select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in `ADDR_WIDTH`: byte address.
- `pwdata` in `DATA_WIDTH`: write data.
- `pready` out 1: transfer complete; registered.
- `pslverr` out 1: transfer error; valid only while `pready`=1; registered.
- `prdata` out `DATA_WIDTH`: read data; valid only while `pready`=1; registered.

## Operation
- **FSM states:** IDLE, WAIT, ACK; binary encoded.
- **IDLE:**
  - A setup phase is `psel`=1 and `penable`=0.
  - On a setup phase, latch `pwrite`, `paddr`, `pwdata` and the error flag.
  - If `WAIT_CYCLE`=0, go to ACK. Otherwise load the 4-bit counter with `WAIT_CYCLE` and go to WAIT.
- **WAIT:**
  - While `psel`=1, decrement the counter each cycle.
  - When the counter is 1, go to ACK.
  - If `psel`=0 (master abort), go to IDLE with no side effect.
- **ACK:**
  - `pready`=1 for exactly one cycle.
  - Next state is always IDLE, so back-to-back transfers start with a fresh setup phase.
- **Word index:** (`paddr` − `BASE_ADDR`) >> 2, truncated to log2(`MEM_SIZE`) bits.
- **Read:**
  - `prdata` is loaded from the memory at the edge entering ACK.
  - On error, `prdata` is forced to 0.
  - `prdata` is 0 in every cycle outside ACK.
- **Write:** the memory is updated at the edge ending ACK, only if the latched `pwrite`=1, `psel`=1, `penable`=1 and there is no error. An erroring write leaves the memory unchanged.
- **Memory reset:** all words clear to 0 on reset.
- **Idle bus:** `pready` stays low whenever the slave is idle. This is required because the master only leaves IDLE when it sees `pready`=0.

## Timing
- **Reset values:** `pready`=0, `pslverr`=0, `prdata`=0, state IDLE, counter 0, latched registers 0.
- **Latency:** with setup phase in cycle 0, `pready` is high in cycle `WAIT_CYCLE`+1.
  - Zero-wait case: `pready` is high in cycle 1, the first access cycle.
- **Read data:** `prdata` and `pslverr` change only on the edge entering ACK and clear on the edge leaving it.
- **Read-after-write:** a read issued after a write completes returns the new data. There is no same-cycle hazard, since a transfer is at least 2 cycles.
- **Reset mid-transfer:** the FSM returns to IDLE immediately and asynchronously. The in-flight write is not committed. `pready` drops at once.
- **Ignored inputs:** a setup phase seen in WAIT or ACK is ignored. Changes to `paddr`, `pwdata` or `pwrite` after setup are ignored; the latched values are used.

## Configuration
- **Macro:** `APB_MEM_SLAVE_ERR_EN`.
- **Defined:**
  - The error flag is set when `paddr` < `BASE_ADDR`, when `paddr` ≥ `BASE_ADDR` + 4·`MEM_SIZE`, or when `paddr[1:0]` ≠ 0.
  - `pslverr`=1 in ACK for a flagged transfer; reads return 0 and writes are dropped.
- **Undefined:**
  - The error flag is constant 0 and `pslverr` is tied 0.
  - Out-of-range addresses alias modulo `MEM_SIZE` words.
  - `paddr[1:0]` is ignored.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → `pready`=0, `pslverr`=0, `prdata`=0; a read of 0x0000_0010 returns 0.
- **Write then read, `WAIT_CYCLE`=1:**
  - Write 0xDEAD_BEEF to 0x0000_0004, then read 0x0000_0004 → `prdata`=0xDEAD_BEEF.
  - Each transfer shows `pready` low for 1 access cycle, then high for 1 cycle.
- **Wait-state sweep:** for `WAIT_CYCLE`=0, 3 and 15 → `pready` rises in cycle 1, 4 and 16 after setup; the zero-wait case shows no WAIT state.
- **Error, with `APB_MEM_SLAVE_ERR_EN`:**
  - Write 0x1234_5678 to `BASE_ADDR`+0x400 (`MEM_SIZE`=256) → `pslverr`=1; word 0 is unchanged.
  - Read 0x0000_0002 → `pslverr`=1, `prdata`=0.
  - Without the macro, the same write lands in word 0.
- **Abort and reset mid-transfer:**
  - Drop `psel` during WAIT (`WAIT_CYCLE`=3) → return to IDLE, `pready` never asserts, memory unchanged.
  - Assert `rst_n`=0 during ACK of a write → data not committed.
- **Integration:** drive with `apb_master` (`start`=1, `wr`=1, address 0x8, data 0xA5A5_A5A5), then a read → the master's `rdata`=0xA5A5_A5A5 and no FSM deadlock.
